// File: rtl/updown_seq_checker.sv
// -----------------------------------------------------------------------------
// updown_seq_checker
//
// Receive-side checker for a bouncing up/down counter stream (0 -> MAX -> 0,
// never wrapping). It watches sampled counter values, works out the count
// direction from the first clean pair, locks onto the ping-pong sequence and
// flags every sample that breaks it. Direction, lock state, a wrapping
// turnaround count and a saturating error count are reported.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active low
//   in_valid   in   q_in carries a sample this cycle
//   q_in       in   [WIDTH]  sampled counter value
//   dir        out  tracked direction (0 = up, 1 = down)
//   locked     out  high while the tracker follows the sequence
//   expected   out  [WIDTH]  prediction for the next sample (valid while locked)
//   err        out  one-cycle pulse on a sequence violation
//   err_count  out  [ERRW]   saturating violation count
//   turn_count out  [TURNW]  wrapping count of turnarounds at MAX and at 0
//
// All outputs are registered; a sample's effect is visible one cycle after it
// is presented.
//
// Build option:
//   UPDOWN_CHK_TOLERATE_EN  -- when defined, a single isolated mismatch while
//   locked is reported but does not drop lock; the tracker steps along its own
//   prediction instead. A second consecutive mismatch drops lock.
// -----------------------------------------------------------------------------
module updown_seq_checker #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8,
  parameter int TURNW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] q_in,
  output logic             dir,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic [ERRW-1:0]  err_count,
  output logic [TURNW-1:0] turn_count
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Value predicted to follow 'last' when moving in direction 'd'.
  // The ends reflect instead of wrapping.
  function automatic logic [WIDTH-1:0] pred_val(input logic [WIDTH-1:0] last,
                                                input logic             d);
    logic [WIDTH-1:0] v;
    if (!d) v = (last == MAX)  ? (MAX - ONE) : (last + ONE);
    else    v = (last == ZERO) ? ONE         : (last - ONE);
    return v;
  endfunction

  // Direction after accepting the predicted sample.
  function automatic logic pred_dir(input logic [WIDTH-1:0] last,
                                    input logic             d);
    return d ? (last != ZERO) : (last == MAX);
  endfunction

  // True when the predicted sample reverses direction.
  function automatic logic pred_turn(input logic [WIDTH-1:0] last,
                                     input logic             d);
    return d ? (last == ZERO) : (last == MAX);
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
    return (c == '1) ? c : (c + ERRW'(1));
  endfunction

  state_t             r_state,      w_state;
  logic [WIDTH-1:0]   r_last,       w_last;
  logic               r_dir,        w_dir;
  logic               r_locked,     w_locked;
  logic [WIDTH-1:0]   r_expected,   w_expected;
  logic               r_err,        w_err;
  logic [ERRW-1:0]    r_err_count,  w_err_count;
  logic [TURNW-1:0]   r_turn_count, w_turn_count;
`ifdef UPDOWN_CHK_TOLERATE_EN
  logic               r_miss,       w_miss;
`endif

  logic [WIDTH-1:0]   w_pred;
  logic               w_pred_dir;
  logic               w_pred_turn;

  assign w_pred      = pred_val(r_last, r_dir);
  assign w_pred_dir  = pred_dir(r_last, r_dir);
  assign w_pred_turn = pred_turn(r_last, r_dir);

  always_comb begin
    w_state      = r_state;
    w_last       = r_last;
    w_dir        = r_dir;
    w_locked     = r_locked;
    w_expected   = r_expected;
    w_err        = 1'b0;
    w_err_count  = r_err_count;
    w_turn_count = r_turn_count;
`ifdef UPDOWN_CHK_TOLERATE_EN
    w_miss       = r_miss;
`endif

    if (in_valid) begin
      case (r_state)
        IDLE: begin
          w_last  = q_in;
          w_state = SYNC;
        end

        SYNC: begin
          // Direction is inferred from a strictly adjacent pair; the ends
          // are guarded so MAX->0 and 0->MAX never look adjacent.
          w_last = q_in;
          if ((r_last != MAX) && (q_in == r_last + ONE)) begin
            w_dir    = 1'b0;
            w_locked = 1'b1;
            w_state  = TRACK;
`ifdef UPDOWN_CHK_TOLERATE_EN
            w_miss   = 1'b0;
`endif
          end else if ((r_last != ZERO) && (q_in == r_last - ONE)) begin
            w_dir    = 1'b1;
            w_locked = 1'b1;
            w_state  = TRACK;
`ifdef UPDOWN_CHK_TOLERATE_EN
            w_miss   = 1'b0;
`endif
          end else begin
            w_err       = 1'b1;
            w_err_count = sat_inc(r_err_count);
          end
        end

        TRACK: begin
          if (q_in == w_pred) begin
            w_last = q_in;
            w_dir  = w_pred_dir;
            if (w_pred_turn) w_turn_count = r_turn_count + TURNW'(1);
`ifdef UPDOWN_CHK_TOLERATE_EN
            w_miss = 1'b0;
`endif
          end else begin
            w_err       = 1'b1;
            w_err_count = sat_inc(r_err_count);
`ifdef UPDOWN_CHK_TOLERATE_EN
            if (!r_miss) begin
              // Ride through one bad sample by stepping along the prediction.
              w_last = w_pred;
              w_dir  = w_pred_dir;
              if (w_pred_turn) w_turn_count = r_turn_count + TURNW'(1);
              w_miss = 1'b1;
            end else begin
              w_locked = 1'b0;
              w_last   = q_in;
              w_state  = SYNC;
              w_miss   = 1'b0;
            end
`else
            w_locked = 1'b0;
            w_last   = q_in;
            w_state  = SYNC;
`endif
          end
        end

        default: begin
          w_state = IDLE;
        end
      endcase

      // Prediction always reflects the state that will hold after this sample.
      w_expected = pred_val(w_last, w_dir);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last       <= '0;
      r_dir        <= 1'b0;
      r_locked     <= 1'b0;
      r_expected   <= '0;
      r_err        <= 1'b0;
      r_err_count  <= '0;
      r_turn_count <= '0;
`ifdef UPDOWN_CHK_TOLERATE_EN
      r_miss       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_last       <= w_last;
      r_dir        <= w_dir;
      r_locked     <= w_locked;
      r_expected   <= w_expected;
      r_err        <= w_err;
      r_err_count  <= w_err_count;
      r_turn_count <= w_turn_count;
`ifdef UPDOWN_CHK_TOLERATE_EN
      r_miss       <= w_miss;
`endif
    end
  end

  assign dir        = r_dir;
  assign locked     = r_locked;
  assign expected   = r_expected;
  assign err        = r_err;
  assign err_count  = r_err_count;
  assign turn_count = r_turn_count;

endmodule

// File: doc/updown_seq_checker.md
Name: updown_seq_checker

Overview:
- Receive-side companion to the team's bouncing up/down counter (0→MAX→0 ping-pong, no wrap).
- Samples a counter value stream, infers count direction, locks onto the sequence and flags every sample that breaks the ping-pong pattern.
- Reports direction, lock state, turnaround count and error count.
- Sits downstream of any counter or link carrying a counter value, for self-check and debug.

Parameters:
- WIDTH, 4, bit width of the sampled counter value; MAX = 2^WIDTH-1.
- ERRW, 8, width of the saturating error counter.
- TURNW, 16, width of the wrapping turnaround counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  q_in carries a sample this cycle.
- q_in  in  WIDTH  sampled counter value.
- dir  out  1  tracked direction; 0 = up, 1 = down.
- locked  out  1  high while in TRACK.
- expected  out  WIDTH  value predicted for the next sample; valid while locked.
- err  out  1  one-cycle pulse on a sequence violation.
- err_count  out  ERRW  saturating count of violations.
- turn_count  out  TURNW  wrapping count of observed turnarounds at MAX and at 0.

Behaviour:
- Reset is sampled on the clk rising edge with rst = 0. It forces:
  - state = IDLE, last = 0
  - dir = 0, locked = 0, expected = 0, err = 0
  - err_count = 0, turn_count = 0
- Reset overrides in_valid in the same cycle.
- All outputs are registered. The response to a sample appears 1 cycle after the in_valid edge.
- Cycles with in_valid = 0:
  - state, last, dir, expected and both counters hold.
  - err = 0.
- IDLE:
  - On a valid sample: last <= q_in, go to SYNC.
  - err stays 0.
- SYNC, on a valid sample s:
  - Up pair: s == last+1 with last != MAX. Then dir <= 0, locked <= 1, go to TRACK.
  - Down pair: s == last-1 with last != 0. Then dir <= 1, locked <= 1, go to TRACK.
  - Any other value, including s == last: err pulse, err_count++, stay in SYNC.
  - last <= s in all cases.
- Prediction rule, computed from last and dir:
  - Up, last < MAX: expected = last+1, dir stays 0.
  - Up, last == MAX: expected = MAX-1, next dir = 1 (turnaround).
  - Down, last > 0: expected = last-1, dir stays 1.
  - Down, last == 0: expected = 1, next dir = 0 (turnaround).
  - The expected output always shows the prediction for the next sample.
- TRACK, on a valid sample s:
  - Match (s == expected): last <= s, dir updated. On a turnaround, turn_count++.
  - Mismatch: err pulse, err_count++, locked <= 0, last <= s, go to SYNC.
- Counter widths:
  - err_count saturates at 2^ERRW-1.
  - turn_count wraps modulo 2^TURNW.
- No arithmetic wrap is ever accepted:
  - MAX→0 is an error.
  - 0→MAX is an error.
- A first TRACK sample that is itself a turnaround counts: last = MAX, dir = 0, s = MAX-1 gives turn_count++.
- Reset mid-TRACK: the next cycle is IDLE with all counters cleared.

Optional Feature:
- Macro: UPDOWN_CHK_TOLERATE_EN.
- Without it: behaviour exactly as above. A single mismatch drops lock.
- With it:
  - First mismatch in TRACK: err pulse and err_count++, but locked stays 1.
  - The tracker advances as if the sample had matched: last <= expected, dir and turn_count updated per the prediction rule.
  - An internal miss flag is set on that first mismatch.
  - A second consecutive mismatch: err pulse, err_count++, locked <= 0, last <= s, go to SYNC.
  - Any matching sample clears the miss flag.
  - Reset clears the miss flag.

Test Plan:
- Reset, then feed 0,1,2…15,14…0,1 with in_valid every cycle. Required response:
  - locked = 1 one cycle after sample "1".
  - err never asserts.
  - turn_count = 2 at the end.
  - dir = 1 after sample 14; dir = 0 after the final sample 1.
- Lock at 5,6, then feed 7,9. Required response:
  - err pulses once.
  - err_count = 1, locked = 0.
  - Then feeding 10,11 relocks with dir = 0 and expected = 12.
- Up ramp to 15, then feed 0. Required response: err pulses and err_count = 1 (wrap rejected).
- Feed 3,3,3,2. Required response:
  - err_count = 1 after the second 3, and 2 after the third 3.
  - Lock on 3→2 with dir = 1 and expected = 1.
- Lock at 8,9, hold in_valid = 0 for 10 cycles, then feed 10. Required response:
  - Outputs are frozen during the gap.
  - Sample 10 is accepted, err = 0.
- Drive rst = 0 mid-ramp at value 12 while in_valid = 1. Required response:
  - The next cycle shows all outputs zero.
  - The first later sample enters SYNC only, with no err.
- With UPDOWN_CHK_TOLERATE_EN, lock at 4,5, then:
  - Feed 9: err pulses, locked stays 1, expected = 7.
  - Feed 7: accepted.
  - Feed 0,0: err_count = 3, locked = 0.
